// File: rtl/m2_block_writer.sv
// Post-IDCT block writer: drains one 8x8 block from the dual-port buffer,
// clips to 8 bits and writes packed pixel pairs to the Y/U/V SRAM plane.
module m2_block_writer #(
  parameter int          IMG_WIDTH_Y  = 320,
  parameter int          IMG_WIDTH_UV = 160,
  parameter logic [17:0] Y_OFFSET     = 18'd0,
  parameter logic [17:0] U_OFFSET     = 18'd38400,
  parameter logic [17:0] V_OFFSET     = 18'd57600,
  parameter int          FRAC_BITS    = 16
) (
  input  logic        Clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  plane,
  input  logic [5:0]  block_col,
  input  logic [5:0]  block_row,
  input  logic        buf_sel,
  output logic [6:0]  ram_addr_a,
  output logic [6:0]  ram_addr_b,
  input  logic [31:0] ram_rdata_a,
  input  logic [31:0] ram_rdata_b,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        done
);

  localparam logic [17:0] STRIDE_Y  = 18'(IMG_WIDTH_Y / 2);
  localparam logic [17:0] STRIDE_UV = 18'(IMG_WIDTH_UV / 2);
  localparam int          HI        = FRAC_BITS + 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t      r_state;
  state_t      w_state;
  logic [1:0]  r_plane;
  logic [1:0]  w_plane;
  logic [4:0]  r_k;
  logic [4:0]  w_k;
  logic [17:0] r_line;
  logic [17:0] w_line;
  logic [6:0]  r_addr_a;
  logic [6:0]  w_addr_a;
  logic [6:0]  r_addr_b;
  logic [6:0]  w_addr_b;
  logic [17:0] r_sram_addr;
  logic [17:0] w_sram_addr;
  logic [15:0] r_wdata;
  logic [15:0] w_wdata;
  logic        r_we_n;
  logic        w_we_n;
  logic        r_busy;
  logic        w_busy;
  logic        r_done;
  logic        w_done;

  logic        w_accept;
  logic [17:0] w_off_in;
  logic [17:0] w_stride_in;
  logic [17:0] w_stride;
  logic [17:0] w_line_in;

  function automatic logic [7:0] clip(
    input logic [31:0] x
  );
    if (x[31]) return 8'd0;
    if (|x[30:HI+1]) return 8'hFF;
    return x[HI -: 8];
  endfunction

  assign w_accept = start && (plane != 2'd3);

  always_comb begin
    w_off_in    = Y_OFFSET;
    w_stride_in = STRIDE_Y;
    case (plane)
      2'd1: begin
        w_off_in    = U_OFFSET;
        w_stride_in = STRIDE_UV;
      end
      2'd2: begin
        w_off_in    = V_OFFSET;
        w_stride_in = STRIDE_UV;
      end
      default: ;
    endcase
  end

  // Line base folds plane offset, block row and block column together
  assign w_line_in = w_off_in
                   + 18'({block_row, 3'b000}) * w_stride_in
                   + 18'({block_col, 2'b00});

  assign w_stride = (r_plane == 2'd0) ? STRIDE_Y : STRIDE_UV;

  always_comb begin
    w_state     = r_state;
    w_plane     = r_plane;
    w_k         = r_k;
    w_line      = r_line;
    w_addr_a    = r_addr_a;
    w_addr_b    = r_addr_b;
    w_sram_addr = r_sram_addr;
    w_wdata     = r_wdata;
    w_we_n      = 1'b1;
    w_busy      = r_busy;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_accept) begin
          w_plane  = plane;
          w_line   = w_line_in;
          w_addr_a = {buf_sel, 6'd0};
          w_addr_b = {buf_sel, 6'd1};
          w_k      = 5'd0;
          w_busy   = 1'b1;
          w_state  = S_LEAD;
        end
      end
      S_LEAD: begin
        w_addr_a = r_addr_a + 7'd2;
        w_addr_b = r_addr_b + 7'd2;
        w_state  = S_WRITE;
      end
      S_WRITE: begin
        w_we_n      = 1'b0;
        w_wdata     = {clip(ram_rdata_a), clip(ram_rdata_b)};
        w_sram_addr = r_line + 18'(r_k[1:0]);
        // Read addresses run two pairs ahead of the write index
        if (r_k < 5'd30) begin
          w_addr_a = r_addr_a + 7'd2;
          w_addr_b = r_addr_b + 7'd2;
        end
        if (r_k[1:0] == 2'd3) w_line = r_line + w_stride;
        w_k = r_k + 5'd1;
        if (r_k == 5'd31) w_state = S_FINISH;
      end
      S_FINISH: begin
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_plane     <= 2'd0;
      r_k         <= 5'd0;
      r_line      <= 18'd0;
      r_addr_a    <= 7'd0;
      r_addr_b    <= 7'd0;
      r_sram_addr <= 18'd0;
      r_wdata     <= 16'd0;
      r_we_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_plane     <= w_plane;
      r_k         <= w_k;
      r_line      <= w_line;
      r_addr_a    <= w_addr_a;
      r_addr_b    <= w_addr_b;
      r_sram_addr <= w_sram_addr;
      r_wdata     <= w_wdata;
      r_we_n      <= w_we_n;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign ram_addr_a      = r_addr_a;
  assign ram_addr_b      = r_addr_b;
  assign SRAM_address    = r_sram_addr;
  assign SRAM_write_data = r_wdata;
  assign SRAM_we_n       = r_we_n;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
